svc_soc_uart_rx_reg: RTL



---
 rtl/svc_soc_uart_rx_pkg.sv | 22 ++
 rtl/svc_uart_rx_phy.sv | 93 +++++++++
 rtl/svc_soc_uart_rx_reg.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/svc_soc_uart_rx_pkg.sv
// Shared constants for the UART receive register block: register offsets,
// STATUS bit positions and PHY FSM state encodings.
package svc_soc_uart_rx_pkg;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_STATS  = 4'h8;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME_ERR = 3;
    localparam int STAT_COUNT_LSB = 8;

    typedef logic [1:0] phy_state_t;

    localparam phy_state_t ST_IDLE  = 2'd0;
    localparam phy_state_t ST_START = 2'd1;
    localparam phy_state_t ST_DATA  = 2'd2;
    localparam phy_state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/svc_uart_rx_phy.sv
// 8N1 receive PHY: 2-flop synchronizer, baud counter and start/data/stop FSM.
// Emits single-cycle byte_valid / frame_err strobes in the stop-bit sample cycle.
module svc_uart_rx_phy
    import svc_soc_uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       urx_pin,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic           sync1;
    logic           sync2;
    logic           line_prev;
    phy_state_t     state;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           tick;

    assign tick = (cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Synchronizer resets to the idle level so reset release cannot fake a start edge.
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
        end else begin
            sync1     <= urx_pin;
            sync2     <= sync1;
            line_prev <= sync2;
            case (state)
                ST_IDLE: begin
                    if (line_prev && !sync2) begin
                        cnt   <= CW'(CLKS_PER_BIT / 2);
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (!sync2) begin
                            // Reload with period-1: the zero cycle itself is the last count.
                            cnt     <= CW'(CLKS_PER_BIT - 1);
                            bit_idx <= '0;
                            state   <= ST_DATA;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg   <= {sync2, shreg[7:1]};
                        cnt     <= CW'(CLKS_PER_BIT - 1);
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign byte_valid = (state == ST_STOP) && tick && sync2;
    assign frame_err  = (state == ST_STOP) && tick && !sync2;
    assign rx_byte    = shreg;

endmodule

// File: rtl/svc_soc_uart_rx_reg.sv
// Memory-mapped UART receiver: PHY, receive FIFO, sticky flags and DATA/STATUS read decode.
// Optional receive counter at offset 0x8 when SVC_SOC_UART_RX_STATS_EN is defined.
module svc_soc_uart_rx_reg
    import svc_soc_uart_rx_pkg::*;
#(
    parameter int          CLOCK_FREQ = 100_000_000,
    parameter int          BAUD_RATE  = 115_200,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        urx_pin,
    input  logic        io_ren,
    input  logic [31:0] io_raddr,
    output logic [31:0] io_rdata,
    output logic        rx_avail
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int AW           = $clog2(FIFO_DEPTH);

    logic        byte_valid;
    logic [7:0]  rx_byte;
    logic        frame_err_pulse;

    svc_uart_rx_phy #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_phy (
        .clk        (clk),
        .rst_n      (rst_n),
        .urx_pin    (urx_pin),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err_pulse)
    );

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          overrun_set;
    logic          overrun_q;
    logic          frame_err_q;

    logic          hit;
    logic [3:0]    ofs;
    logic          data_rd;
    logic          status_rd;
    logic [8:0]    count_wide;
    logic [7:0]    count_sat;
    logic [31:0]   status_word;
    logic [31:0]   rdata_next;
    logic [1:0]    unused_addr_bits;

    assign unused_addr_bits = io_raddr[1:0];

    assign hit       = io_ren && (io_raddr[31:4] == BASE_ADDR[31:4]);
    assign ofs       = {io_raddr[3:2], 2'b00};
    assign data_rd   = hit && (ofs == REG_DATA);
    assign status_rd = hit && (ofs == REG_STATUS);

    assign empty       = (count == '0);
    assign full        = (count == (AW+1)'(FIFO_DEPTH));
    assign pop         = data_rd && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push        = byte_valid && (!full || pop);
    assign overrun_set = byte_valid && full && !pop;

    // NOTE: always_comb assigns every output a default first so no latch is inferred.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: FIFO storage is deliberately not reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_avail    <= 1'b0;
            io_rdata    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count       <= count_next;
            // Set terms are ORed last so a coincident STATUS read cannot swallow a new event.
            overrun_q   <= overrun_set     || (overrun_q   && !status_rd);
            frame_err_q <= frame_err_pulse || (frame_err_q && !status_rd);
            rx_avail    <= (count_next != '0);
            io_rdata    <= rdata_next;
        end
    end

`ifdef SVC_SOC_UART_RX_STATS_EN
    logic [31:0] rx_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_count <= '0;
        end else if (push) begin
            rx_count <= rx_count + 32'd1;
        end
    end
`endif

    assign count_wide = 9'(count);
    assign count_sat  = count_wide[8] ? 8'hFF : count_wide[7:0];

    always_comb begin
        status_word                              = '0;
        status_word[STAT_NOT_EMPTY]              = !empty;
        status_word[STAT_FULL]                   = full;
        status_word[STAT_OVERRUN]                = overrun_q;
        status_word[STAT_FRAME_ERR]              = frame_err_q;
        status_word[STAT_COUNT_LSB +: 8]         = count_sat;
    end

    always_comb begin
        rdata_next = '0;
        if (hit) begin
            case (ofs)
                REG_DATA: begin
                    if (!empty) rdata_next = {23'b0, 1'b1, mem[rd_ptr]};
                end
                REG_STATUS: rdata_next = status_word;
`ifdef SVC_SOC_UART_RX_STATS_EN
                REG_STATS:  rdata_next = rx_count;
`endif
                default:    rdata_next = '0;
            endcase
        end
    end

endmodule
